// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner. It blanks each digit slot briefly before driving it.
// New display data is double-buffered so that it only takes effect on a frame boundary.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 25_000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digit_data,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_mask,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [15:0] SLOT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BLANK_END = 16'(BLANK_CYC - 1);

  state_t      state;
  logic [15:0] slot_cnt;
  logic [1:0]  digit_idx;

  logic [15:0] disp_data;
  logic [3:0]  disp_dp;
  logic [3:0]  disp_mask;
  logic [15:0] stg_data;
  logic [3:0]  stg_dp;
  logic [3:0]  stg_mask;
  logic        pending;

  logic        slot_end;
  logic        xfer;
  logic [3:0]  cur_nib;

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign xfer     = slot_end && (digit_idx == 2'd3);
  assign cur_nib  = disp_data[{digit_idx, 2'b00} +: 4];

  // Active-high {g,f,e,d,c,b,a} glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      slot_cnt   <= '0;
      digit_idx  <= '0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_mask  <= '0;
      stg_data   <= '0;
      stg_dp     <= '0;
      stg_mask   <= '0;
      pending    <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? 16'd0 : slot_cnt + 16'd1;
      if (slot_end) begin
        digit_idx <= digit_idx + 2'd1;
      end

      case (state)
        BLANK:   if (slot_cnt == BLANK_END) state <= DRIVE;
        default: if (slot_end) state <= BLANK;
      endcase

      // Outputs lag the scan position by one cycle.
      if (state == DRIVE) begin
        an <= ~(4'b0001 << digit_idx);
        if (disp_mask[digit_idx]) begin
          seg <= 7'h7F;
          dp  <= 1'b1;
        end else begin
          seg <= ~glyph(cur_nib);
          dp  <= ~disp_dp[digit_idx];
        end
      end else begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end

      frame_done <= xfer;

      // A load landing on the transfer cycle bypasses staging and wins over older staged data.
      if (xfer) begin
        if (load) begin
          disp_data <= digit_data;
          disp_dp   <= dp_in;
          disp_mask <= blank_mask;
        end else if (pending) begin
          disp_data <= stg_data;
          disp_dp   <= stg_dp;
          disp_mask <= stg_mask;
        end
        pending <= 1'b0;
      end else if (load) begin
        stg_data <= digit_data;
        stg_dp   <= dp_in;
        stg_mask <= blank_mask;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=8 and BLANK_CYC=2 (8-cycle slots, 32-cycle frames).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Scan position of the current window and the cycle number at which that position started.
  int   pos  = 0;
  int   base = 0;
  logic [15:0] e_data = '0;
  logic [3:0]  e_dp   = '0;
  logic [3:0]  e_mask = '0;

  logic [6:0] glyph_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(int p, logic [15:0] d, logic [3:0] dpv, logic [3:0] m);
    exp_t r;
    int slot = p % 8;
    int dig  = (p / 8) % 4;
    logic [3:0] nib;
    r.cyc = 0;
    r.an  = 4'hF;
    r.seg = 7'h7F;
    r.dp  = 1'b1;
    r.fd  = ((p % 32) == 31);
    r.tag = $sformatf("scan_p%0d_d%0d", p, dig);
    if (slot >= 2) begin
      r.an[dig] = 1'b0;
      if (!m[dig]) begin
        nib   = d[dig*4 +: 4];
        r.seg = ~glyph_hi[nib];
        r.dp  = ~dpv[dig];
      end
    end
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    e     = model(pos, e_data, e_dp, e_mask);
    e.cyc = base + pos + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    pos++;
  endtask

  task automatic run_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic load_tick(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] m);
    digit_data = d;
    dp_in      = dpv;
    blank_mask = m;
    load       = 1'b1;
    tick();
  endtask

  task automatic reset_tick();
    exp_t e;
    rst_n = 1'b0;
    e.cyc = base + pos + 1;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fd  = 1'b0;
    e.tag = "reset";
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    load   = 1'b0;
    base   = base + pos + 1;
    pos    = 0;
    e_data = '0;
    e_dp   = '0;
    e_mask = '0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc || an !== mon_e.an || seg !== mon_e.seg ||
          dp !== mon_e.dp || frame_done !== mon_e.fd) begin
        errors++;
        $display("FAIL %s cyc=%0d(want %0d): got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                 mon_e.tag, cyc, mon_e.cyc, an, seg, dp, frame_done,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, %0d expectations left", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    digit_data = '0;
    dp_in      = '0;
    blank_mask = '0;
    @(posedge clk);
    #1;
    base = cyc;
    pos  = 0;
    repeat (3) reset_tick();

    // Frames 0-1 show zeros; a mid-frame load in frame 1 must wait for frame 2.
    run_to(42);
    load_tick(16'h12AF, 4'b0100, 4'b0000);
    run_to(64);

    // Frame 2 shows 12AF; two loads, the last one wins in frame 3.
    e_data = 16'h12AF; e_dp = 4'b0100; e_mask = 4'b0000;
    run_to(69);
    load_tick(16'h1111, 4'b0000, 4'b0000);
    run_to(84);
    load_tick(16'h2222, 4'b0000, 4'b0000);
    run_to(96);

    // Frame 3 shows 2222; a load exactly in the transfer cycle goes straight to frame 4.
    e_data = 16'h2222; e_dp = 4'b0000; e_mask = 4'b0000;
    run_to(127);
    load_tick(16'h5555, 4'b0000, 4'b1000);

    // Frames 4-5 show 5555 with digit 3 masked; stale staged 2222 must not reappear.
    e_data = 16'h5555; e_dp = 4'b0000; e_mask = 4'b1000;
    run_to(163);
    load_tick(16'h9876, 4'b1111, 4'b0000);
    run_to(179);

    // Reset during digit 2 drive drops the pending 9876.
    reset_tick();
    run_to(64);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
